mult32_seq: RTL and testbench
=============================

Name: mult32_seq

Overview:
- Sequential unsigned 32x32->64 shift-add multiplier for the ALU.
- Drives the existing 32-bit ripple adder (adder32) as its only arithmetic resource and consumes its sum/cout every iteration.
- Sits beside the adder in the ALU; the control unit issues a start pulse and waits for done.
- Trades 33 cycles of latency for zero extra adders.

Parameters:
- WIDTH, 32, operand width. Only 32 is legal because the datapath is adder32; assert at elaboration if WIDTH != 32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when idle or in the done cycle.
- a  input  32  multiplicand; sampled on the accepting edge.
- b  input  32  multiplier; sampled on the accepting edge.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; product is valid.
- product  output  64  result; held until the next accepted start.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, product=0, count=0, internal registers=0. rst has priority over every other input.
- States:
  - IDLE: on start=1, load mcand<=a, acc_hi<=0, acc_lo<=b, count<=0, go to RUN.
  - RUN: each cycle, adder inputs are a=acc_hi, b=(acc_lo[0] ? mcand : 0), cin=0. Then {acc_hi,acc_lo} <= {cout,sum,acc_lo[31:1]}, count<=count+1. After the 32nd iteration (count==31), go to DONE.
  - DONE: done=1 for exactly one cycle; product={acc_hi,acc_lo}. On start=1, load new operands and go to RUN (back-to-back); otherwise go to IDLE.
- Timing: start high in cycle 0 -> busy=1 in cycles 1..32 -> done=1 and product valid in cycle 33.
- product is a register updated only on entry to DONE. It is stable in IDLE and during a following operation, until the next DONE.
- start while busy=1 is ignored; it is not queued. a/b changes during RUN have no effect.
- Carry: cout of every iteration must be captured into acc_hi[31] via the shift; no bits are dropped.
- Edge values: b=0 -> product=0 in cycle 33 (still 33 cycles; no early exit). 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001.
- rst asserted mid-RUN: next cycle is IDLE with all outputs 0. The aborted result never appears.
- busy and done are never high together.

Optional Feature:
- Macro MULT32_OVF_EN.
- Defined: adds output port ovf (1 bit), registered with product. ovf=1 iff product[63:32] != 0, i.e. the result does not fit in 32 bits. Reset value 0; held like product.
- Undefined: no ovf port and no associated logic; all other behaviour identical.

Decomposition:
- Package mult32_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - MULT_WIDTH=32, ITER_LAST=5'd31, PROD_WIDTH=64
- Sub-module: instantiate the existing adder32 unchanged (datapath).
- FSM, counter and shift registers stay in mult32_seq.

Test Plan:
- Reset, then start with a=7, b=6 -> busy cycles 1..32, done pulse in cycle 33 only, product=0x0000000000000002A.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001. With MULT32_OVF_EN defined, ovf=1.
- a=0x12345678, b=0; then a=1, b=0x80000000 -> product=0 after 33 cycles; then product=0x0000000080000000 with ovf=0.
- start a=3, b=5; pulse start a=9, b=9 in cycle 10 -> ignored, product=15.
- start a=3, b=5; raise start with a=2, b=2 in the done cycle -> product=15 at first done, then product=4 exactly 33 cycles later.
- start a=100, b=100; assert rst in cycle 15 -> cycle 16 IDLE, busy=0, done=0, product=0, no done pulse follows.

Source files
------------

// File: rtl/mult32_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mult32_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned MULT_WIDTH = 32;
  localparam logic [4:0]  ITER_LAST  = 5'd31;
  localparam int unsigned PROD_WIDTH = 64;

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-carry adder shared with the ALU; the multiplier's only arithmetic resource.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < 32; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    cout = w_c[32];
  end

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier built around adder32 (33-cycle latency).
// Optional overflow flag output enabled by defining MULT32_OVF_EN.
module mult32_seq
  import mult32_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
`ifdef MULT32_OVF_EN
  output logic                  ovf,
`endif
  output logic [PROD_WIDTH-1:0] product
);

  if (WIDTH != 32) begin : g_bad_width
    $error("mult32_seq: WIDTH must be 32 (datapath is adder32)");
  end

  state_t                r_state, w_next_state;
  logic [31:0]           r_mcand, r_acc_hi, r_acc_lo;
  logic [4:0]            r_count;
  logic [PROD_WIDTH-1:0] r_product;
  logic [31:0]           w_add_b, w_sum;
  logic                  w_cout, w_load, w_last;

  assign w_add_b = r_acc_lo[0] ? r_mcand : '0;
  assign w_load  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last  = (r_state == S_RUN) && (r_count == ITER_LAST);

  adder32 u_adder (
    .a    (r_acc_hi),
    .b    (w_add_b),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (r_count == ITER_LAST) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_mcand  <= a;
        r_acc_hi <= '0;
        r_acc_lo <= b;
        r_count  <= '0;
      end else if (r_state == S_RUN) begin
        // cout lands in acc_hi[31] through the right shift, so no carry is lost
        {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[31:1]};
        r_count              <= r_count + 5'd1;
      end
      if (w_last) r_product <= {w_cout, w_sum, r_acc_lo[31:1]};
    end
  end

`ifdef MULT32_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_cout | (|w_sum[31:1]);
  end

  assign ovf = r_ovf;
`endif

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: driver queues expected products, monitor checks each done pulse.
module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;
`ifdef MULT32_OVF_EN
  logic        ovf;
`endif

  mult32_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
`ifdef MULT32_OVF_EN
    .ovf     (ovf),
`endif
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", product, e.prod);
          check("done_cycle", 64'(cyc), 64'(e.cyc));
`ifdef MULT32_OVF_EN
          check("ovf", {63'd0, ovf}, {63'd0, (e.prod[63:32] != 32'd0)});
`endif
        end
      end
    end
  end

  // Caller is just past a negedge; waits for an accepting cycle, then drives start for one cycle.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb);
    exp_t e;
    int unsigned guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("issue_timeout", 64'd1, 64'd0);
    start = 1'b1;
    a = xa;
    b = xb;
    e.prod = 64'(xa) * 64'(xb);
    e.cyc  = cyc + 33;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while ((sb.size() != 0 || busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", {63'd0, guard >= 200}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst = 1'b0;

    // 7*6 with explicit busy/done timeline
    issue(32'd7, 32'd6);
    for (int i = 1; i <= 32; i++) begin
      check("busy_run", {63'd0, busy}, 64'd1);
      check("done_run", {63'd0, done}, 64'd0);
      @(negedge clk);
    end
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("done_pulse", {63'd0, done}, 64'd1);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("product_held", product, 64'h2A);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    check("max_product", product, 64'hFFFF_FFFE_0000_0001);

    issue(32'h1234_5678, 32'd0);
    issue(32'd1, 32'h8000_0000);
    drain();

    // start pulse during RUN must be ignored
    issue(32'd3, 32'd5);
    repeat (9) @(negedge clk);
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("ignored_start", product, 64'd15);

    // back-to-back: second issue lands in the done cycle
    issue(32'd3, 32'd5);
    issue(32'd2, 32'd2);
    repeat (10) @(negedge clk);
    check("product_held_next_run", product, 64'd15);
    drain();

    // reset in cycle 15 of a run aborts it
    issue(32'd100, 32'd100);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", product, 64'd0);
    sb.delete();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_result", product, 64'd0);

    // randomized operands with random idle gaps
    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (n % 6 == 1) rb = 32'd0;
      if (n % 6 == 2) ra = 32'hFFFF_FFFF;
      if (n % 4 == 3) begin
        ra = $urandom_range(0, 65535);
        rb = $urandom_range(0, 65535);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(ra, rb);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
